// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Holds the register index and data widths, the FIFO entry layout and the hard-wired zero register.
package wb_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous DEPTH-entry FIFO for long-latency results. DEPTH must be a power of two,
// so both pointers wrap for free. A push into a full FIFO or a pop from an empty one is ignored.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output wb_entry_t pop_data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // NOTE: storage is left unreset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates the single register-file write port between the ALU and queued long-latency results,
// and keeps a busy scoreboard for decode. Define WB_PERF_EN to add the perf_blocked counter.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NREG  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_reg,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [REG_IDX_W-1:0] lsu_reg,
  input  logic [DATA_W-1:0]    lsu_data,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_reg,
  input  logic [REG_IDX_W-1:0] query_reg1,
  input  logic [REG_IDX_W-1:0] query_reg2,
  output logic                 busy1,
  output logic                 busy2,
  output logic                 issue_busy,
  output logic                 reg_write,
  output logic [REG_IDX_W-1:0] write_reg,
  output logic [DATA_W-1:0]    write_data
`ifdef WB_PERF_EN
  ,
  output logic [15:0]          perf_blocked
`endif
);

  wb_entry_t push_entry, head;
  logic      fifo_full, fifo_empty;
  logic      push_en, pop_en;

  assign push_entry = '{idx: lsu_reg, data: lsu_data};
  assign lsu_ready  = !fifo_full;
  assign push_en    = lsu_valid && !fifo_full;
  // The ALU cannot be back-pressured, so it always wins the port.
  assign pop_en     = !fifo_empty && !alu_valid;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_en),
    .push_data_i(push_entry),
    .pop_i      (pop_en),
    .pop_data_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  logic [NREG-1:0] busy_q, busy_d;

  assign busy1      = busy_q[query_reg1];
  assign busy2      = busy_q[query_reg2];
  assign issue_busy = busy_q[issue_reg];

  // NOTE: always_comb starts from a full default so no path leaves a signal unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    if (pop_en) busy_d[head.idx] = 1'b0;
    // Applied after the clear so a same-cycle set wins.
    if (issue_valid && issue_reg != REG_ZERO) busy_d[issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  logic                 reg_write_q, reg_write_d;
  logic [REG_IDX_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0]    write_data_q, write_data_d;

  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (alu_valid) begin
      reg_write_d  = (alu_reg != REG_ZERO);
      write_reg_d  = alu_reg;
      write_data_d = alu_data;
    end else if (pop_en) begin
      reg_write_d  = (head.idx != REG_ZERO);
      write_reg_d  = head.idx;
      write_data_d = head.data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      busy_q       <= busy_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

`ifdef WB_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (!fifo_empty && alu_valid && perf_q != 16'hFFFF) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_blocked = perf_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed-vector bench for writeback_arbiter: reset, ALU path, FIFO path with scoreboard,
// fill/contention, register 0 handling and reset mid-drain.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_reg = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_reg = '0;
  logic [31:0] lsu_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_reg = '0;
  logic [4:0]  query_reg1 = '0;
  logic [4:0]  query_reg2 = '0;
  logic        busy1, busy2, issue_busy;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
`ifdef WB_PERF_EN
  logic [15:0] perf_blocked;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  writeback_arbiter #(.DEPTH(4), .NREG(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_reg    (alu_reg),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_reg    (lsu_reg),
    .lsu_data   (lsu_data),
    .issue_valid(issue_valid),
    .issue_reg  (issue_reg),
    .query_reg1 (query_reg1),
    .query_reg2 (query_reg2),
    .busy1      (busy1),
    .busy2      (busy2),
    .issue_busy (issue_busy),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data)
`ifdef WB_PERF_EN
    ,
    .perf_blocked(perf_blocked)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; registered outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [4:0] r,
                            input logic [31:0] d);
    check({tag, ".reg_write"}, 32'(reg_write), 32'(we));
    check({tag, ".write_reg"}, 32'(write_reg), 32'(r));
    check({tag, ".write_data"}, write_data, d);
  endtask

  initial begin
    // Reset and idle
    #22 rst_n = 1'b1;
    query_reg1 = 5'd7;
    query_reg2 = 5'd8;
    issue_reg  = 5'd9;
    for (int i = 0; i < 3; i++) tick();
    check_port("reset", 1'b0, 5'd0, 32'h0);
    check("reset.lsu_ready", 32'(lsu_ready), 32'd1);
    check("reset.busy1", 32'(busy1), 32'd0);
    check("reset.busy2", 32'(busy2), 32'd0);
    check("reset.issue_busy", 32'(issue_busy), 32'd0);
`ifdef WB_PERF_EN
    check("reset.perf", 32'(perf_blocked), 32'd0);
`endif

    // ALU only
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    check_port("alu", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check_port("alu_idle", 1'b0, 5'd5, 32'hDEADBEEF);

    // Issue r7, then push its result through the FIFO
    issue_valid = 1'b1; issue_reg = 5'd7; query_reg1 = 5'd7;
    #1 check("issue.busy1_before", 32'(busy1), 32'd0);
    tick();
    issue_valid = 1'b0;
    #1 check("issue.busy1_after", 32'(busy1), 32'd1);
    check("issue.issue_busy", 32'(issue_busy), 32'd1);
    lsu_valid = 1'b1; lsu_reg = 5'd7; lsu_data = 32'h12345678;
    tick();
    lsu_valid = 1'b0;
    #1 check("lsu.no_write_yet", 32'(reg_write), 32'd0);
    check("lsu.busy1_pending", 32'(busy1), 32'd1);
    tick();
    check_port("lsu", 1'b1, 5'd7, 32'h12345678);
    check("lsu.busy1_cleared", 32'(busy1), 32'd0);

    // Fill the FIFO while the ALU holds the port every cycle
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hA0 + 32'(i);
      lsu_valid = 1'b1; lsu_reg = 5'(10 + i); lsu_data = 32'h100 + 32'(i);
      #1 check($sformatf("fill%0d.ready", i), 32'(lsu_ready), 32'd1);
      tick();
      check_port($sformatf("fill%0d.alu", i), 1'b1, 5'd3, 32'hA0 + 32'(i));
    end
    lsu_valid = 1'b0;
    alu_data  = 32'hB0;
    #1 check("full.ready", 32'(lsu_ready), 32'd0);
    tick();
    check_port("full.alu", 1'b1, 5'd3, 32'hB0);
`ifdef WB_PERF_EN
    check("full.perf", 32'(perf_blocked), 32'd4);
`endif
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_port($sformatf("drain%0d", i), 1'b1, 5'(10 + i), 32'h100 + 32'(i));
      check($sformatf("drain%0d.ready", i), 32'(lsu_ready), 32'd1);
    end
    tick();
    check_port("drain_done", 1'b0, 5'd13, 32'h103);
`ifdef WB_PERF_EN
    check("drain.perf", 32'(perf_blocked), 32'd4);
`endif

    // Register 0: ALU, issue and FIFO entry
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h55;
    issue_valid = 1'b1; issue_reg = 5'd0; query_reg1 = 5'd0;
    tick();
    alu_valid = 1'b0; issue_valid = 1'b0;
    check_port("r0.alu", 1'b0, 5'd0, 32'h55);
    check("r0.busy1", 32'(busy1), 32'd0);
    check("r0.issue_busy", 32'(issue_busy), 32'd0);
    lsu_valid = 1'b1; lsu_reg = 5'd0; lsu_data = 32'h66;
    tick();
    lsu_reg = 5'd9; lsu_data = 32'h99;
    tick();
    lsu_valid = 1'b0;
    check_port("r0.lsu", 1'b0, 5'd0, 32'h66);
    tick();
    check_port("r0.next", 1'b1, 5'd9, 32'h99);
    tick();
    check_port("r0.empty", 1'b0, 5'd9, 32'h99);

    // Reset mid-drain with three entries still queued
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_reg = 5'(20 + i);
      tick();
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'hC0;
      lsu_valid = 1'b1; lsu_reg = 5'(20 + i); lsu_data = 32'h200 + 32'(i);
      tick();
    end
    lsu_valid = 1'b0; alu_valid = 1'b0;
    tick();
    check_port("rst.pre_drain", 1'b1, 5'd20, 32'h200);
    query_reg1 = 5'd21; query_reg2 = 5'd22; issue_reg = 5'd23;
    #1 check("rst.busy_before", 32'({busy1, busy2, issue_busy}), 32'h7);
    rst_n = 1'b0;
    #1 check_port("rst.async", 1'b0, 5'd0, 32'h0);
    check("rst.busy1", 32'(busy1), 32'd0);
    check("rst.busy2", 32'(busy2), 32'd0);
    check("rst.issue_busy", 32'(issue_busy), 32'd0);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_port($sformatf("rst.post%0d", i), 1'b0, 5'd0, 32'h0);
    end
    check("rst.lsu_ready", 32'(lsu_ready), 32'd1);
`ifdef WB_PERF_EN
    check("rst.perf", 32'(perf_blocked), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
